// File: rtl/telem_frame_rx.sv
// telem_frame_rx -- telemetry frame receiver for the eBike TX link monitor.
//
// Consumes the UART_rcv byte stream, locates the HDR0/HDR1 header, rebuilds
// NUM_CH channel words (two bytes each, high byte first) and publishes them
// as one atomically updated register bank. An optional XOR checksum byte
// and an inter-byte timeout guard the frame.
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   byte_vld   received byte available (UART_rcv rdy)
//   byte_in    received byte (UART_rcv rx_data)
//   byte_ack   one-cycle consume pulse (UART_rcv clr_rdy)
//   ch_data    channel words, ch k at [k*DATA_W +: DATA_W], ch0 first in frame
//   frame_vld  one-cycle pulse, ch_data has just been updated
//   frame_cnt  good frames received, wraps
//   chk_err    one-cycle pulse, checksum mismatch
//   to_err     one-cycle pulse, inter-byte timeout
//   err_cnt    chk_err + to_err events, saturating
//
// Handshake: a byte is taken in any cycle with byte_vld=1 and byte_ack=0.
// byte_ack is registered and is high exactly the cycle after that, which
// gives UART_rcv one cycle to drop rdy, so no byte is ever taken twice and
// at most one byte is taken per two cycles.
module telem_frame_rx #(
  parameter int         NUM_CH      = 3,
  parameter int         DATA_W      = 12,
  parameter logic [7:0] HDR0        = 8'hAA,
  parameter logic [7:0] HDR1        = 8'h55,
  parameter bit         CHK_EN      = 1'b0,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     byte_vld,
  input  logic [7:0]               byte_in,
  output logic                     byte_ack,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     frame_vld,
  output logic [15:0]              frame_cnt,
  output logic                     chk_err,
  output logic                     to_err,
  output logic [7:0]               err_cnt
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int HI_W  = DATA_W - 8;

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           idx, idx_nxt;
  logic [7:0]                 xor_q, xor_nxt;
  logic [TO_W-1:0]            to_cnt;
  logic [NUM_CH*DATA_W-1:0]   stage, stage_nxt;
  logic                       accept;
  logic                       expire;
  logic                       commit;
  logic                       chk_bad;

  assign accept = byte_vld & ~byte_ack;

  // A byte accepted in the expiry cycle wins, so the frame keeps going.
  assign expire = (state != S_HDR0) && !accept &&
                  (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    xor_nxt   = xor_q;
    stage_nxt = stage;
    commit    = 1'b0;
    chk_bad   = 1'b0;
    if (accept) begin
      case (state)
        S_HDR0: begin
          if (byte_in == HDR0) state_nxt = S_HDR1;
        end
        S_HDR1: begin
          if (byte_in == HDR1) begin
            state_nxt = S_HI;
            idx_nxt   = '0;
            xor_nxt   = '0;
          end else if (byte_in != HDR0) begin
            state_nxt = S_HDR0;
          end
        end
        S_HI: begin
          // Upper byte bits beyond DATA_W are dropped without checking.
          stage_nxt[int'(idx)*DATA_W + 8 +: HI_W] = byte_in[HI_W-1:0];
          xor_nxt   = xor_q ^ byte_in;
          state_nxt = S_LO;
        end
        S_LO: begin
          stage_nxt[int'(idx)*DATA_W +: 8] = byte_in;
          xor_nxt = xor_q ^ byte_in;
          if (idx != IDX_W'(NUM_CH - 1)) begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = S_HI;
          end else if (CHK_EN) begin
            state_nxt = S_CHK;
          end else begin
            commit    = 1'b1;
            state_nxt = S_HDR0;
          end
        end
        S_CHK: begin
          if (byte_in == xor_q) commit  = 1'b1;
          else                  chk_bad = 1'b1;
          state_nxt = S_HDR0;
        end
        default: state_nxt = S_HDR0;
      endcase
    end else if (expire) begin
      state_nxt = S_HDR0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HDR0;
      idx       <= '0;
      xor_q     <= '0;
      stage     <= '0;
      to_cnt    <= '0;
      byte_ack  <= 1'b0;
      ch_data   <= '0;
      frame_vld <= 1'b0;
      frame_cnt <= '0;
      chk_err   <= 1'b0;
      to_err    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      xor_q     <= xor_nxt;
      stage     <= stage_nxt;
      byte_ack  <= accept;
      frame_vld <= commit;
      chk_err   <= chk_bad;
      to_err    <= expire;

      if (state == S_HDR0 || accept || expire) to_cnt <= '0;
      else                                     to_cnt <= to_cnt + TO_W'(1);

      // stage_nxt already holds the final low byte on the last-word edge.
      if (commit) begin
        ch_data   <= stage_nxt;
        frame_cnt <= frame_cnt + 16'd1;
      end

      if ((chk_bad || expire) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_telem_frame_rx.sv
// Bench for telem_frame_rx. Three instances share clk/rst:
//   u0: NUM_CH=3, DATA_W=12, CHK_EN=0, TIMEOUT_CYC=100
//   u1: NUM_CH=3, DATA_W=12, CHK_EN=1, TIMEOUT_CYC=100
//   u2: NUM_CH=5, DATA_W=16, CHK_EN=0, TIMEOUT_CYC=100
module tb_telem_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  vld;
  logic [7:0]  din;
  logic [2:0]  ack, fv, ce, te;
  logic [15:0] fc [3];
  logic [7:0]  ec [3];
  logic [35:0] ch0;
  logic [35:0] ch1;
  logic [79:0] ch2;

  always #5 clk = ~clk;

  telem_frame_rx #(.NUM_CH(3), .DATA_W(12), .CHK_EN(1'b0), .TIMEOUT_CYC(100)) u0 (
    .clk(clk), .rst(rst), .byte_vld(vld[0]), .byte_in(din), .byte_ack(ack[0]),
    .ch_data(ch0), .frame_vld(fv[0]), .frame_cnt(fc[0]), .chk_err(ce[0]),
    .to_err(te[0]), .err_cnt(ec[0]));

  telem_frame_rx #(.NUM_CH(3), .DATA_W(12), .CHK_EN(1'b1), .TIMEOUT_CYC(100)) u1 (
    .clk(clk), .rst(rst), .byte_vld(vld[1]), .byte_in(din), .byte_ack(ack[1]),
    .ch_data(ch1), .frame_vld(fv[1]), .frame_cnt(fc[1]), .chk_err(ce[1]),
    .to_err(te[1]), .err_cnt(ec[1]));

  telem_frame_rx #(.NUM_CH(5), .DATA_W(16), .CHK_EN(1'b0), .TIMEOUT_CYC(100)) u2 (
    .clk(clk), .rst(rst), .byte_vld(vld[2]), .byte_in(din), .byte_ack(ack[2]),
    .ch_data(ch2), .frame_vld(fv[2]), .frame_cnt(fc[2]), .chk_err(ce[2]),
    .to_err(te[2]), .err_cnt(ec[2]));

  // Pulse counters, sampled on the falling edge.
  int n_ack [3];
  int n_fv  [3];
  int n_ce  [3];
  int n_te  [3];

  initial for (int i = 0; i < 3; i++) begin
    n_ack[i] = 0; n_fv[i] = 0; n_ce[i] = 0; n_te[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack[i]) n_ack[i]++;
      if (fv[i])  n_fv[i]++;
      if (ce[i])  n_ce[i]++;
      if (te[i])  n_te[i]++;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] ch_of(input int s);
    case (s)
      0:       return {44'd0, ch0};
      1:       return {44'd0, ch1};
      default: return ch2;
    endcase
  endfunction

  // Drive one byte and hold it until the DUT takes it.
  task automatic send(input int s, input logic [7:0] b);
    int guard;
    @(negedge clk);
    din    = b;
    vld[s] = 1'b1;
    guard  = 0;
    while (ack[s] && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 vld[s] = 1'b0;
  endtask

  // raw is right-aligned: byte 0 of the stream is the most significant of n.
  task automatic send_raw(input int s, input int n, input logic [127:0] raw);
    for (int j = 0; j < n; j++) send(s, raw[8*(n-1-j) +: 8]);
  endtask

  typedef struct {
    string        name;
    int           sel;
    int           n;
    logic [127:0] raw;
    logic [79:0]  exp_ch;
    logic [15:0]  exp_fcnt;
    logic [7:0]   exp_ecnt;
    int           exp_fv;
    int           exp_ce;
  } vec_t;

  vec_t vt [10];

  initial begin
    int a, f, c, t, t0;

    vt[0] = '{"basic",      0,  8, 128'hAA550FFF01230700,       80'h700123FFF, 16'd1, 8'd0, 1, 0};
    vt[1] = '{"resync",     0, 10, 128'h12AAAA550ABC010000FF,   80'h0FF100ABC, 16'd2, 8'd0, 1, 0};
    vt[2] = '{"hdr_as_data",0,  8, 128'hAA55AA550AAA5500,       80'h500AAAA55, 16'd3, 8'd0, 1, 0};
    vt[3] = '{"upper_drop", 0,  8, 128'hAA55FF00F1110001,       80'h001111F00, 16'd4, 8'd0, 1, 0};
    vt[4] = '{"chk_good",   1,  9, 128'hAA550ABC010000FF48,     80'h0FF100ABC, 16'd1, 8'd0, 1, 0};
    vt[5] = '{"chk_bad",    1,  9, 128'hAA550ABC010000FF49,     80'h0FF100ABC, 16'd1, 8'd1, 0, 1};
    vt[6] = '{"chk_good2",  1,  9, 128'hAA5501020304050607,     80'h506304102, 16'd2, 8'd1, 1, 0};
    vt[7] = '{"chk_bad2",   1,  9, 128'hAA5501020304050608,     80'h506304102, 16'd2, 8'd2, 0, 1};
    vt[8] = '{"wide5x16",   2, 12, 128'hAA55123456789ABCDEF01122, 80'h1122DEF09ABC56781234, 16'd1, 8'd0, 1, 0};
    vt[9] = '{"hdr_abort",  0, 10, 128'hAA12AA55010203040506,   80'h506304102, 16'd5, 8'd0, 1, 0};

    rst = 1'b1;
    vld = '0;
    din = '0;
    repeat (3) @(negedge clk);
    chk("rst_ch0",   ch_of(0), 80'd0);
    chk("rst_ch2",   ch_of(2), 80'd0);
    chk("rst_fcnt0", 80'(fc[0]), 80'd0);
    chk("rst_ecnt1", 80'(ec[1]), 80'd0);
    chk("rst_pulses", 80'({ack, fv, ce, te}), 80'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      a = n_ack[vt[i].sel];
      f = n_fv[vt[i].sel];
      c = n_ce[vt[i].sel];
      send_raw(vt[i].sel, vt[i].n, vt[i].raw);
      repeat (2) @(negedge clk);
      chk({vt[i].name, "_ch"},   ch_of(vt[i].sel), vt[i].exp_ch);
      chk({vt[i].name, "_fcnt"}, 80'(fc[vt[i].sel]), 80'(vt[i].exp_fcnt));
      chk({vt[i].name, "_ecnt"}, 80'(ec[vt[i].sel]), 80'(vt[i].exp_ecnt));
      chk({vt[i].name, "_acks"}, 80'(n_ack[vt[i].sel] - a), 80'(vt[i].n));
      chk({vt[i].name, "_fv"},   80'(n_fv[vt[i].sel] - f), 80'(vt[i].exp_fv));
      chk({vt[i].name, "_ce"},   80'(n_ce[vt[i].sel] - c), 80'(vt[i].exp_ce));
    end
    chk("no_timeouts", 80'(n_te[0] + n_te[1] + n_te[2]), 80'd0);

    // Timeout: header plus one payload byte, then silence.
    t0 = n_te[0];
    send(0, 8'hAA);
    send(0, 8'h55);
    send(0, 8'h0A);
    t = 0;
    while (!te[0] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("to_latency", 80'((t >= 98 && t <= 104) ? 1 : 0), 80'd1);
    repeat (150) @(negedge clk);
    chk("to_once",   80'(n_te[0] - t0), 80'd1);
    chk("to_ecnt",   80'(ec[0]), 80'd1);
    chk("to_ch_kept", ch_of(0), 80'h506304102);
    chk("to_fcnt",   80'(fc[0]), 80'd5);
    send_raw(0, 8, 128'hAA550FFF01230700);
    repeat (2) @(negedge clk);
    chk("after_to_ch",   ch_of(0), 80'h700123FFF);
    chk("after_to_fcnt", 80'(fc[0]), 80'd6);

    // frame_cnt wrap on the wide instance.
    force u2.frame_cnt = 16'hFFFF;
    send_raw(2, 11, 128'hAA5500010002000300040005 >> 8);
    release u2.frame_cnt;
    a = n_fv[2];
    send(2, 8'h05);
    repeat (2) @(negedge clk);
    chk("wrap_fcnt", 80'(fc[2]), 80'd0);
    chk("wrap_ch",   ch_of(2), 80'h00050004000300020001);
    chk("wrap_fv",   80'(n_fv[2] - a), 80'd1);

    // Reset while u0 waits for the low byte of channel 1.
    send_raw(0, 5, 128'hAA55010203);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ch0",  ch_of(0), 80'd0);
    chk("mid_rst_ch2",  ch_of(2), 80'd0);
    chk("mid_rst_fcnt", 80'(fc[0]), 80'd0);
    chk("mid_rst_ecnt", 80'(ec[0]), 80'd0);
    @(negedge clk);
    rst = 1'b0;
    send_raw(0, 8, 128'hAA550ABC010000FF);
    repeat (2) @(negedge clk);
    chk("post_rst_ch",   ch_of(0), 80'h0FF100ABC);
    chk("post_rst_fcnt", 80'(fc[0]), 80'd1);
    chk("post_rst_ecnt", 80'(ec[0]), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
